// File: rtl/program_counter_pkg.sv
// Shared types and default parameters for the fetch-stage program counter.
// Replaces the old DefinitionsPC.v include: state encodings and default reset address.
package program_counter_pkg;

   typedef enum logic [1:0] {
      PC_BOOT  = 2'd0,
      PC_RUN   = 2'd1,
      PC_FLUSH = 2'd2
   } pc_state_e;

   localparam int PC_ADDR_WIDTH_DEF = 10;
   localparam int PC_RESET_ADDR_DEF = 0;
   localparam int PC_RAS_DEPTH_DEF  = 4;

endpackage

// File: rtl/program_counter_if.sv
// Decode/hazard <-> fetch bundle; the master side is decode/hazard, the slave side is the PC.
interface program_counter_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  stall;
   logic                  branch_taken;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic                  call;
   logic                  ret;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_valid;
   logic                  flush;
   logic                  stack_err;

   modport master (
      output stall, branch_taken, branch_target, call, ret,
      input  pc, pc_valid, flush, stack_err
   );

   modport slave (
      input  stall, branch_taken, branch_target, call, ret,
      output pc, pc_valid, flush, stack_err
   );
endinterface

// File: rtl/program_counter_return_stack.sv
// Circular hardware return-address stack: push overwrites the oldest entry when full,
// pop on empty returns EMPTY_VALUE; both conditions are reported as single-cycle pulses.
module return_stack
   import program_counter_pkg::*;
#(
   parameter int               DEPTH       = PC_RAS_DEPTH_DEF,
   parameter int               WIDTH       = PC_ADDR_WIDTH_DEF,
   parameter logic [WIDTH-1:0] EMPTY_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             overflow_o,
   output logic             underflow_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic [PW-1:0]    top_ptr;
   logic             empty;
   logic             full;
   logic             do_push;

   assign top_ptr = wr_ptr_q - PW'(1);
   assign empty   = (count_q == '0);
   assign full    = (count_q == (PW+1)'(DEPTH));
   // Pop wins if both are requested; the pointer wraps naturally because DEPTH is a power of two.
   assign do_push = push_i & ~pop_i;

   assign top_o       = empty ? EMPTY_VALUE : mem_q[top_ptr];
   assign overflow_o  = do_push & full;
   assign underflow_o = pop_i & empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop_i) begin
         if (!empty) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - (PW+1)'(1);
         end
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (!full) begin
            count_d = count_q + (PW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage PC: sequential fetch, branch redirect with one-cycle flush, stall hold.
// Define RET_STACK_EN to build the call/return stack; without it iCall/iReturn are ignored.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int                    ADDR_WIDTH = PC_ADDR_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(PC_RESET_ADDR_DEF),
   parameter int                    RAS_DEPTH  = PC_RAS_DEPTH_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   program_counter_if.slave   bus_if
);

   pc_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  flush_q;
   logic                  err_q, err_d;

   logic                  ret_req;
   logic                  call_req;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] ras_top;
   logic                  ras_over;
   logic                  ras_under;

`ifdef RET_STACK_EN
   assign ret_req  = bus_if.ret;
   assign call_req = bus_if.call;

   // The pushed value is the pre-edge PC, i.e. the fall-through address of the call.
   return_stack #(
      .DEPTH       (RAS_DEPTH),
      .WIDTH       (ADDR_WIDTH),
      .EMPTY_VALUE (RESET_ADDR)
   ) u_return_stack (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_q),
      .top_o       (ras_top),
      .overflow_o  (ras_over),
      .underflow_o (ras_under)
   );
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_stack_ctl;

   assign ret_req          = 1'b0;
   assign call_req         = 1'b0;
   assign ras_top          = RESET_ADDR;
   assign ras_over         = 1'b0;
   assign ras_under        = 1'b0;
   assign unused_stack_ctl = bus_if.call ^ bus_if.ret ^ push ^ pop;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         PC_BOOT: begin
            state_d = PC_RUN;
         end
         PC_RUN: begin
            if (ret_req) begin
               pc_d    = ras_top;
               pop     = 1'b1;
               state_d = PC_FLUSH;
            end else if (bus_if.branch_taken) begin
               pc_d    = bus_if.branch_target;
               push    = call_req;
               state_d = PC_FLUSH;
            end else if (!bus_if.stall) begin
               pc_d = pc_q + ADDR_WIDTH'(1);
            end
         end
         PC_FLUSH: begin
            // Decode inputs belong to the killed instruction; only the stall matters here.
            if (!bus_if.stall) begin
               pc_d    = pc_q + ADDR_WIDTH'(1);
               state_d = PC_RUN;
            end
         end
         default: begin
            state_d = PC_BOOT;
         end
      endcase
      err_d = err_q | ras_over | ras_under;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PC_BOOT;
         pc_q    <= RESET_ADDR;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= (state_d == PC_FLUSH);
         err_q   <= err_d;
      end
   end

   assign bus_if.pc        = pc_q;
   assign bus_if.pc_valid  = (state_q != PC_BOOT);
   assign bus_if.flush     = flush_q;
   assign bus_if.stack_err = err_q;

endmodule
